// File: rtl/uart_alu_interface_if.sv
// uart_alu_interface_if
//   Bundles the UART / ALU side signals of the command sequencer.
//   slave  : the sequencer's view (UART/ALU strobes and data in, ALU operands
//            and transmit request out).
//   master : the environment's view (UART rx/tx, ALU model).
//   Signals:
//     i_rx_data/i_rx_done   byte from UART receiver, one-cycle strobe
//     i_tx_done             UART transmitter finished the stop bit
//     i_alu_result          combinational ALU output
//     o_alu_a/o_alu_b/o_alu_op  registered ALU operands and opcode
//     o_tx_data/o_tx_start  result byte and one-cycle start pulse
//     o_busy/o_overrun      command in flight / sticky dropped-byte flag
interface uart_alu_interface_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_done;
    logic                  i_tx_done;
    logic [DATA_WIDTH-1:0] i_alu_result;
    logic [DATA_WIDTH-1:0] o_alu_a;
    logic [DATA_WIDTH-1:0] o_alu_b;
    logic [OP_WIDTH-1:0]   o_alu_op;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_start;
    logic                  o_busy;
    logic                  o_overrun;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun
    );
endinterface

// File: rtl/uart_alu_interface.sv
// uart_alu_interface
//   Command sequencer between UART and a combinational ALU. Collects operand A,
//   operand B and opcode bytes, latches the ALU result one cycle after the
//   opcode arrives, pulses a transmit start and waits for tx_done before the
//   next command. Bytes arriving while a command is in flight are dropped and
//   flagged in a sticky overrun bit.
//   Ports:
//     i_clk  system clock
//     i_rst  synchronous active-high reset
//     bus    uart_alu_interface_if.slave (see interface header)
//   OP_WIDTH must not exceed DATA_WIDTH; the opcode is the low OP_WIDTH bits
//   of the third byte.
module uart_alu_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    uart_alu_interface_if.slave   bus
);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [OP_WIDTH-1:0]   r_alu_op;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_overrun;
    logic                  w_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_WAIT_A;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_A:  if (bus.i_rx_done) w_next = S_WAIT_B;
            S_WAIT_B:  if (bus.i_rx_done) w_next = S_WAIT_OP;
            S_WAIT_OP: if (bus.i_rx_done) w_next = S_EXEC;
            S_EXEC:    w_next = S_SEND;
            S_SEND:    w_next = S_WAIT_TX;
            // rx_done arriving together with tx_done is still an overrun; the
            // byte is not taken as the next operand A.
            S_WAIT_TX: if (bus.i_tx_done) w_next = S_WAIT_A;
            default:   w_next = S_WAIT_A;
        endcase
    end

    assign w_busy = (r_state == S_EXEC) || (r_state == S_SEND) || (r_state == S_WAIT_TX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.i_rx_done) begin
                case (r_state)
                    S_WAIT_A:  r_alu_a  <= bus.i_rx_data;
                    S_WAIT_B:  r_alu_b  <= bus.i_rx_data;
                    S_WAIT_OP: r_alu_op <= bus.i_rx_data[OP_WIDTH-1:0];
                    default:   r_overrun <= 1'b1;
                endcase
            end
            // ALU inputs changed at the edge entering EXEC, so the result is
            // settled by the end of EXEC.
            if (r_state == S_EXEC) r_tx_data <= bus.i_alu_result;
        end
    end

    assign bus.o_alu_a    = r_alu_a;
    assign bus.o_alu_b    = r_alu_b;
    assign bus.o_alu_op   = r_alu_op;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = (r_state == S_SEND);
    assign bus.o_busy     = w_busy;
    assign bus.o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_interface.sv
module tb_uart_alu_interface;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   seen = 0;

    uart_alu_interface_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus();

    uart_alu_interface #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour used both as the attached ALU and as the expected result.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = ref_alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    // Abstract model: bytes collected so far, command in flight, start seen.
    int         m_idx = 0;
    bit         m_busy = 0;
    bit         m_txseen = 0;
    bit         m_ovr = 0;
    logic [7:0] m_a, m_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: status every cycle, scoreboard pop on every tx_start.
    bit prev_start = 0;
    always @(negedge clk) begin
        chk("busy", bus.o_busy, m_busy);
        chk("overrun", bus.o_overrun, m_ovr);
        if (bus.o_tx_start) begin
            seen++;
            chk("start_single", prev_start, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL start_unexpected: got tx_start expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tx_data", bus.o_tx_data, e.res);
                chk("alu_a", bus.o_alu_a, e.a);
                chk("alu_b", bus.o_alu_b, e.b);
                chk("alu_op", bus.o_alu_op, e.op);
                chk("start_latency", cyc, e.cyc);
            end
        end
        prev_start = bus.o_tx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_tx = 0);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        bus.i_tx_done = with_tx;
        tick();
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        if (m_busy) begin
            m_ovr = 1;
            if (with_tx && m_txseen) begin
                m_busy = 0;
                m_txseen = 0;
            end
        end else begin
            case (m_idx)
                0: m_a = b;
                1: m_b = b;
                default: begin
                    exp_t e;
                    e.a = m_a; e.b = m_b; e.op = b[5:0];
                    e.res = ref_alu(m_a, m_b, b[5:0]);
                    e.cyc = cyc + 1;
                    exp_q.push_back(e);
                    m_busy = 1;
                end
            endcase
            m_idx = (m_idx + 1) % 3;
        end
    endtask

    task automatic pulse_tx();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        if (m_busy && m_txseen) begin
            m_busy = 0;
            m_txseen = 0;
        end
    endtask

    task automatic wait_start();
        int s0 = seen;
        int n = 0;
        while (seen == s0 && n < 12) begin
            tick();
            n++;
        end
        chk("start_timeout", (seen != s0), 1);
        m_txseen = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_idx = 0; m_busy = 0; m_txseen = 0; m_ovr = 0;
        exp_q.delete();
    endtask

    task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_start();
    endtask

    task automatic chk_all_zero();
        chk("rst_a", bus.o_alu_a, 0);
        chk("rst_b", bus.o_alu_b, 0);
        chk("rst_op", bus.o_alu_op, 0);
        chk("rst_tx", bus.o_tx_data, 0);
        chk("rst_start", bus.o_tx_start, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_ovr", bus.o_overrun, 0);
    endtask

    localparam logic [5:0] OPS [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

    initial begin
        rst = 1'b1;
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        tick();
        do_reset();
        chk_all_zero();

        // basic command
        cmd(8'h05, 8'h03, 8'h20);
        chk("t1_a", bus.o_alu_a, 8'h05);
        chk("t1_b", bus.o_alu_b, 8'h03);
        chk("t1_op", bus.o_alu_op, 8'h20);
        chk("t1_tx", bus.o_tx_data, 8'h08);
        pulse_tx();
        chk("t1_idle", bus.o_busy, 0);

        // opcode truncation
        cmd(8'h01, 8'h02, 8'hE2);
        chk("t2_op", bus.o_alu_op, 8'h22);
        chk("t2_tx", bus.o_tx_data, 8'hFF);
        pulse_tx();

        // overrun in WAIT_TX
        cmd(8'h09, 8'h04, 8'h20);
        send_byte(8'hAA);
        chk("t3_ovr", bus.o_overrun, 1);
        chk("t3_a", bus.o_alu_a, 8'h09);
        chk("t3_busy", bus.o_busy, 1);
        pulse_tx();
        cmd(8'h01, 8'h01, 8'h20);
        chk("t3_tx", bus.o_tx_data, 8'h02);
        chk("t3_ovr_sticky", bus.o_overrun, 1);
        pulse_tx();

        // rx_done and tx_done together in WAIT_TX
        cmd(8'h03, 8'h03, 8'h24);
        send_byte(8'h77, 1);
        chk("t4_idle", bus.o_busy, 0);
        chk("t4_ovr", bus.o_overrun, 1);
        chk("t4_a_kept", bus.o_alu_a, 8'h03);
        send_byte(8'h10);
        chk("t4_a_new", bus.o_alu_a, 8'h10);
        send_byte(8'h05);
        send_byte(8'h20);
        wait_start();
        chk("t4_tx", bus.o_tx_data, 8'h15);
        pulse_tx();

        // reset mid-command
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        chk_all_zero();
        cmd(8'h04, 8'h02, 8'h20);
        chk("t5_tx", bus.o_tx_data, 8'h06);
        pulse_tx();

        // spurious tx_done in WAIT_A and WAIT_B
        pulse_tx();
        chk("t6_idle", bus.o_busy, 0);
        send_byte(8'h07);
        pulse_tx();
        send_byte(8'h08);
        chk("t6_b", bus.o_alu_b, 8'h08);
        send_byte(8'h20);
        wait_start();
        chk("t6_tx", bus.o_tx_data, 8'h0F);
        pulse_tx();

        // randomized commands with gaps, back-to-back overruns, spurious tx_done
        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            op = {2'($urandom), OPS[$urandom_range(0, 4)]};
            if ($urandom_range(0, 3) == 0) pulse_tx();
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            send_byte(op);
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
            wait_start();
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), 1);
            else pulse_tx();
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Command sequencer between the UART and the ALU. It collects three consecutive bytes from the UART receiver: operand A, operand B, then the opcode. It presents them to the combinational ALU and captures the result. It then hands the result byte to the UART transmitter and waits for transmission to finish before accepting the next command.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: operand, result and UART payload width.
- `OP_WIDTH`, default 6: ALU opcode width. Must be ≤ `DATA_WIDTH`. The opcode is the low `OP_WIDTH` bits of the third byte.

**Ports**
- `i_clk` in, 1: system clock. One clock domain for the whole block.
- `i_rst` in, 1: reset. Synchronous and active-high.
- `i_rx_data` in, `DATA_WIDTH`: received byte from the UART receiver. Valid only in a cycle where `i_rx_done`=1.
- `i_rx_done` in, 1: one-cycle pulse from the UART receiver, byte received.
- `i_tx_done` in, 1: one-cycle pulse from the UART transmitter, stop bit finished.
- `i_alu_result` in, `DATA_WIDTH`: combinational ALU output.
- `o_alu_a` out, `DATA_WIDTH`: registered operand A.
- `o_alu_b` out, `DATA_WIDTH`: registered operand B.
- `o_alu_op` out, `OP_WIDTH`: registered opcode.
- `o_tx_data` out, `DATA_WIDTH`: registered result byte for the transmitter.
- `o_tx_start` out, 1: one-cycle pulse that starts transmission.
- `o_busy` out, 1: high in states EXEC, SEND and WAIT_TX.
- `o_overrun` out, 1: sticky flag. Set when a byte arrives while busy; cleared only by reset.

## Operation

- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- Reset state is WAIT_A.
- WAIT_A, on `i_rx_done`: `o_alu_a` ← `i_rx_data`, go to WAIT_B.
- WAIT_B, on `i_rx_done`: `o_alu_b` ← `i_rx_data`, go to WAIT_OP.
- WAIT_OP, on `i_rx_done`: `o_alu_op` ← `i_rx_data[OP_WIDTH-1:0]`, go to EXEC. Upper bits are discarded.
- EXEC: unconditionally `o_tx_data` ← `i_alu_result`, go to SEND.
- SEND: `o_tx_start`=1, a Moore output decoded from state. Go to WAIT_TX unconditionally.
- WAIT_TX, on `i_tx_done`: go to WAIT_A. Otherwise stay.
- Registers hold their values until overwritten. `o_alu_a`, `o_alu_b`, `o_alu_op` and `o_tx_data` keep the last command's values after returning to WAIT_A.
- `i_rx_done` in EXEC, SEND or WAIT_TX: the byte is dropped and `o_overrun` ← 1. No register changes and no state change.
- `i_tx_done` outside WAIT_TX is ignored.
- There is no timeout. WAIT_TX waits indefinitely for `i_tx_done`.

## Timing

- Every register updates on the `i_clk` rising edge.
- Reset values: state=WAIT_A; `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data` = 0; `o_tx_start`=0; `o_busy`=0; `o_overrun`=0.
- Reset is sampled at the edge. Reset mid-command (any state) aborts the command. Partially received operands are cleared. A pending transmission is abandoned with no further `o_tx_start`.
- Latency: opcode `i_rx_done` sampled at edge k puts the FSM in EXEC after k. Result is latched at k+1. `o_tx_start` is high for exactly the cycle between edges k+1 and k+2. State is WAIT_TX after k+2.
- `i_alu_result` must be settled one cycle after `o_alu_op` updates. The ALU is combinational, so this is met.
- `o_tx_start` is never high for more than one consecutive cycle. It occurs exactly once per completed three-byte command.
- `i_tx_done` and `i_rx_done` in the same cycle in WAIT_TX:
  - Next state is WAIT_A.
  - The received byte is dropped and `o_overrun` is set.
  - The byte is not stored as operand A.
- Back-to-back pulses on consecutive cycles are accepted, one per cycle. An `i_rx_done` held high for two cycles counts as two bytes.
- `o_busy` equals (state ∈ {EXEC, SEND, WAIT_TX}), decoded from the state register with no extra delay.

## Test plan

1. **Basic command.** After reset, send bytes 0x05, 0x03, 0x20 (ADD) with an adder model returning A+B.
   - Expect `o_alu_a`=0x05, `o_alu_b`=0x03, `o_alu_op`=0x20.
   - Expect `o_tx_data`=0x08 and exactly one `o_tx_start` pulse, 2 cycles after the third `i_rx_done`.
   - After `i_tx_done`, `o_busy`=0.
2. **Opcode truncation.** Third byte 0xE2 with `OP_WIDTH`=6 → `o_alu_op`=0x22.
3. **Overrun.** While in WAIT_TX, pulse `i_rx_done` with 0xAA.
   - Expect `o_overrun`=1, with `o_alu_a` and the state unchanged.
   - After `i_tx_done`, the next command 0x01, 0x01, 0x20 yields `o_tx_data`=0x02.
   - `o_overrun` stays 1.
4. **Simultaneous done.** In WAIT_TX, assert `i_rx_done` (0x77) and `i_tx_done` in the same cycle.
   - Expect state WAIT_A and `o_overrun`=1.
   - The next byte 0x10 lands in `o_alu_a`.
5. **Reset mid-command.** Send 0x11, 0x22, then assert `i_rst` one cycle.
   - All outputs read 0.
   - Bytes 0x04, 0x02, 0x20 then produce `o_tx_data`=0x06.
6. **Spurious tx_done.** Pulse `i_tx_done` in WAIT_A and WAIT_B. No state change. A following full command completes normally.
